// File: rtl/inst_mem_loader_if.sv
// Byte-stream input and instruction-memory write port
// of the program loader.
interface inst_mem_loader_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start;
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output start,
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  start,
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/inst_mem_loader.sv
// Loads a length-framed little-endian byte stream into
// instruction memory and holds the core until complete.
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  inst_mem_loader_if.slave  bus,
  output logic [ADDR_WIDTH:0] o_words_loaded,
  output logic              o_done,
  output logic              o_error,
  output logic              o_cpu_hold
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [15:0] LP_MAX = 16'(MAX_WORDS);

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_byte_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic                  r_done;
  logic                  r_error;
  logic                  r_cpu_hold;
  logic [15:0]           r_len;
  logic [1:0]            r_idx;

  logic                  w_xfer;
  logic [15:0]           w_len;
  logic [ADDR_WIDTH:0]   w_cnt_inc;
  logic                  w_last;

  assign w_xfer    = bus.byte_valid & r_byte_ready;
  assign w_len     = {bus.byte_data, r_len[7:0]};
  assign w_cnt_inc = r_words_loaded + 1'b1;
  assign w_last    = (16'(w_cnt_inc) == r_len);

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_nxt = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (w_xfer) w_state_nxt = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          if (w_len == 16'd0)
            w_state_nxt = S_DONE;
          else if (w_len > LP_MAX)
            w_state_nxt = S_ERROR;
          else
            w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_xfer && r_idx == 2'd3)
          w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        w_state_nxt = w_last ? S_DONE : S_DATA;
      end
      S_DONE, S_ERROR: begin
        if (bus.start) w_state_nxt = S_LEN_LO;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status outputs are registered from the next state so
  // they line up with the state they describe.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_byte_ready   <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_words_loaded <= '0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_cpu_hold     <= 1'b1;
      r_len          <= '0;
      r_idx          <= '0;
    end else begin
      r_byte_ready <= (w_state_nxt == S_LEN_LO) ||
                      (w_state_nxt == S_LEN_HI) ||
                      (w_state_nxt == S_DATA);
      r_mem_we     <= (w_state_nxt == S_WRITE);
      r_done       <= (w_state_nxt == S_DONE);
      r_error      <= (w_state_nxt == S_ERROR);
      r_cpu_hold   <= (w_state_nxt != S_DONE);
      unique case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (bus.start) begin
            r_words_loaded <= '0;
            r_mem_addr     <= '0;
            r_idx          <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) r_len[7:0] <= bus.byte_data;
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= bus.byte_data;
            r_mem_addr  <= '0;
            r_idx       <= '0;
          end
        end
        S_DATA: begin
          // First byte ends up in [7:0] after four shifts.
          if (w_xfer) begin
            r_mem_wdata <= {bus.byte_data, r_mem_wdata[31:8]};
            r_idx       <= r_idx + 2'd1;
          end
        end
        S_WRITE: begin
          r_words_loaded <= w_cnt_inc;
          if (!w_last) r_mem_addr <= r_mem_addr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready  = r_byte_ready;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign o_words_loaded  = r_words_loaded;
  assign o_done          = r_done;
  assign o_error         = r_error;
  assign o_cpu_hold      = r_cpu_hold;

endmodule
